// File: rtl/time_set_sequencer.sv
// Time-set controller for the watch: turns mode/next/up presses into an
// h1 -> h0 -> m1 -> m0 edit session and commits the result with a load pulse.
module time_set_sequencer #(
    parameter int TIMEOUT_CYCLES = 30000,
    parameter int BLINK_HALF     = 500,
    parameter int CNT_W          = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_next,
    input  logic       btn_up,
    input  logic       fmt12,
    input  logic [3:0] cur_h1,
    input  logic [3:0] cur_h0,
    input  logic [3:0] cur_m1,
    input  logic [3:0] cur_m0,
    output logic       set_active,
    output logic [1:0] digit_sel,
    output logic       blink,
    output logic       load,
    output logic [3:0] set_h1,
    output logic [3:0] set_h0,
    output logic [3:0] set_m1,
    output logic [3:0] set_m0,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        E_H1   = 3'd1,
        E_H0   = 3'd2,
        E_M1   = 3'd3,
        E_M0   = 3'd4,
        COMMIT = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_HALF - 1);

    state_t           state_q, state_d;
    logic             mode_prev_q, next_prev_q, up_prev_q;
    logic             mode_edge, next_edge, up_edge, any_edge;
    logic             editing;
    logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
    logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
    logic             blink_q, blink_d;
    logic [1:0]       digit_sel_q, digit_sel_d;
    logic [3:0]       h1_q, h0_q, m1_q, m0_q;
    logic [3:0]       h1_d, h0_d, m1_d, m0_d;
    logic [3:0]       h1_inc, h0_inc, h0_lo, h0_hi;

    // Prioritised edges: a mode edge masks next and up, a next edge masks up.
    assign mode_edge = btn_mode & ~mode_prev_q;
    assign next_edge = btn_next & ~next_prev_q & ~mode_edge;
    assign up_edge   = btn_up & ~up_prev_q & ~mode_edge & ~next_edge;
    assign any_edge  = mode_edge | next_edge | up_edge;
    assign editing   = (state_q == E_H1) || (state_q == E_H0) ||
                       (state_q == E_M1) || (state_q == E_M0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (mode_edge) state_d = E_H1;
            end
            E_H1, E_H0, E_M1, E_M0: begin
                if (mode_edge) begin
                    state_d = IDLE;
                end else if (next_edge) begin
                    case (state_q)
                        E_H1:    state_d = E_H0;
                        E_H0:    state_d = E_M1;
                        E_M1:    state_d = E_M0;
                        default: state_d = COMMIT;
                    endcase
                end else if (!up_edge && to_cnt_q == TO_LAST) begin
                    state_d = IDLE;
                end
            end
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        set_active = editing;
        load       = (state_q == COMMIT);
        blink      = blink_q & editing;
        digit_sel  = digit_sel_q;
        dbg_state  = state_q;
    end

    always_comb begin
        case (state_d)
            E_H1:    digit_sel_d = 2'd3;
            E_H0:    digit_sel_d = 2'd2;
            E_M1:    digit_sel_d = 2'd1;
            default: digit_sel_d = 2'd0;
        endcase
    end

    always_comb begin
        to_cnt_d    = (editing && !any_edge) ? to_cnt_q + 1'b1 : '0;
        blink_cnt_d = '0;
        blink_d     = 1'b0;
        if (editing) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_d = ~blink_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
                blink_d     = blink_q;
            end
        end
    end

    // Digit limits depend on the live fmt12 and the current h1.
    always_comb begin
        if (fmt12) begin
            h1_inc = (h1_q >= 4'd1) ? 4'd0 : h1_q + 4'd1;
            h0_lo  = (h1_q == 4'd0) ? 4'd1 : 4'd0;
            h0_hi  = (h1_q == 4'd0) ? 4'd9 : 4'd2;
        end else begin
            h1_inc = (h1_q >= 4'd2) ? 4'd0 : h1_q + 4'd1;
            h0_lo  = 4'd0;
            h0_hi  = (h1_q < 4'd2) ? 4'd9 : 4'd3;
        end
        h0_inc = (h0_q >= h0_hi) ? h0_lo : h0_q + 4'd1;
    end

    always_comb begin
        h1_d = h1_q;
        h0_d = h0_q;
        m1_d = m1_q;
        m0_d = m0_q;
        if (state_q == IDLE && mode_edge) begin
            h1_d = cur_h1;
            h0_d = cur_h0;
            m1_d = cur_m1;
            m0_d = cur_m0;
        end else if (up_edge) begin
            case (state_q)
                E_H1: begin
                    h1_d = h1_inc;
                    if (fmt12) begin
                        if (h1_inc == 4'd1 && h0_q > 4'd2) h0_d = 4'd0;
                        if (h1_inc == 4'd0 && h0_q == 4'd0) h0_d = 4'd1;
                    end else if (h1_inc == 4'd2 && h0_q > 4'd3) begin
                        h0_d = 4'd0;
                    end
                end
                E_H0:    h0_d = h0_inc;
                E_M1:    m1_d = (m1_q >= 4'd5) ? 4'd0 : m1_q + 4'd1;
                E_M0:    m0_d = (m0_q >= 4'd9) ? 4'd0 : m0_q + 4'd1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_prev_q <= 1'b0;
            next_prev_q <= 1'b0;
            up_prev_q   <= 1'b0;
            to_cnt_q    <= '0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
            digit_sel_q <= 2'd0;
            h1_q        <= 4'd0;
            h0_q        <= 4'd0;
            m1_q        <= 4'd0;
            m0_q        <= 4'd0;
        end else begin
            mode_prev_q <= btn_mode;
            next_prev_q <= btn_next;
            up_prev_q   <= btn_up;
            to_cnt_q    <= to_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
            digit_sel_q <= digit_sel_d;
            h1_q        <= h1_d;
            h0_q        <= h0_d;
            m1_q        <= m1_d;
            m0_q        <= m0_d;
        end
    end

    assign set_h1 = h1_q;
    assign set_h0 = h0_q;
    assign set_m1 = m1_q;
    assign set_m0 = m0_q;

endmodule

// File: tb/tb_time_set_sequencer.sv
// Bench for time_set_sequencer: directed scenarios plus random button traffic,
// all compared against a digit-level model of an edit session.
module tb_time_set_sequencer;

    localparam int TO = 40;
    localparam int BH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_mode, btn_next, btn_up, fmt12;
    logic [3:0] cur_h1, cur_h0, cur_m1, cur_m0;
    logic       set_active, blink, load;
    logic [1:0] digit_sel;
    logic [3:0] set_h1, set_h0, set_m1, set_m0;
    logic [2:0] dbg_state;
    logic [20:0] obs;

    int checks = 0;
    int passes = 0;

    // Model: phase 0 idle, 1 editing, 2 committing; digits indexed like digit_sel.
    int         ph, dig, quiet, bt;
    logic [3:0] ms[4];
    logic       pm, pn, pu;

    always #5 clk = ~clk;

    time_set_sequencer #(.TIMEOUT_CYCLES(TO), .BLINK_HALF(BH), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .btn_mode(btn_mode), .btn_next(btn_next), .btn_up(btn_up), .fmt12(fmt12),
        .cur_h1(cur_h1), .cur_h0(cur_h0), .cur_m1(cur_m1), .cur_m0(cur_m0),
        .set_active(set_active), .digit_sel(digit_sel), .blink(blink), .load(load),
        .set_h1(set_h1), .set_h0(set_h0), .set_m1(set_m1), .set_m0(set_m0),
        .dbg_state(dbg_state)
    );

    assign obs = {set_active, digit_sel, blink, load, set_h1, set_h0, set_m1, set_m0};

    task automatic model_reset();
        ph = 0; dig = 0; quiet = 0; bt = 0;
        pm = 1'b0; pn = 1'b0; pu = 1'b0;
        for (int i = 0; i < 4; i++) ms[i] = 4'd0;
    endtask

    task automatic bump(input int d);
        int lo, hi, v;
        lo = 0;
        case (d)
            0: hi = 9;
            1: hi = 5;
            2: begin
                if (fmt12) begin
                    lo = (ms[3] == 0) ? 1 : 0;
                    hi = (ms[3] == 0) ? 9 : 2;
                end else begin
                    hi = (ms[3] < 2) ? 9 : 3;
                end
            end
            default: hi = fmt12 ? 1 : 2;
        endcase
        v = (int'(ms[d]) >= hi) ? lo : int'(ms[d]) + 1;
        ms[d] = 4'(v);
        if (d == 3) begin
            if (fmt12) begin
                if (v == 1 && ms[2] > 2) ms[2] = 4'd0;
                if (v == 0 && ms[2] == 0) ms[2] = 4'd1;
            end else if (v == 2 && ms[2] > 3) begin
                ms[2] = 4'd0;
            end
        end
    endtask

    task automatic model_step();
        logic me, ne, ue;
        me = btn_mode & ~pm;
        ne = btn_next & ~pn;
        ue = btn_up & ~pu;
        pm = btn_mode; pn = btn_next; pu = btn_up;
        if (ph == 2) begin
            ph = 0;
        end else if (ph == 0) begin
            if (me) begin
                ph = 1; dig = 3; quiet = 0; bt = 0;
                ms[3] = cur_h1; ms[2] = cur_h0; ms[1] = cur_m1; ms[0] = cur_m0;
            end
        end else begin
            bt++;
            if (me) begin
                ph = 0;
            end else if (ne) begin
                quiet = 0;
                if (dig == 0) ph = 2;
                else dig--;
            end else if (ue) begin
                quiet = 0;
                bump(dig);
            end else begin
                quiet++;
                if (quiet == TO) ph = 0;
            end
        end
    endtask

    function automatic logic [20:0] exp_obs();
        logic act, bl;
        act = (ph == 1);
        bl  = act && (((bt / BH) % 2) == 1);
        return {act, act ? 2'(dig) : 2'd0, bl, ph == 2, ms[3], ms[2], ms[1], ms[0]};
    endfunction

    // One clock: buttons {mode,next,up} change at negedge, model follows the posedge.
    task automatic tick(input logic [2:0] b);
        @(negedge clk);
        {btn_mode, btn_next, btn_up} = b;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_cur(input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] c, input logic [3:0] d);
        cur_h1 = a; cur_h0 = b; cur_m1 = c; cur_m0 = d;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (obs !== 21'd0 || dbg_state !== 3'd0)
            $display("FAIL reset_state: got %h/%0d expected 0/0", obs, dbg_state);
        else passes++;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(3'b000);
            checks++;
            if (obs !== exp_obs()) $display("FAIL reset_release[%0d]: got %h expected %h", i, obs, exp_obs());
            else passes++;
        end
    endtask

    task automatic test_commit();
        logic [2:0] seq[$] = '{3'b100, 3'b000, 3'b010, 3'b000, 3'b010, 3'b000, 3'b010, 3'b000, 3'b010};
        fmt12 = 1'b0;
        set_cur(4'd1, 4'd4, 4'd3, 4'd7);
        foreach (seq[i]) begin
            tick(seq[i]);
            checks++;
            if (obs !== exp_obs()) $display("FAIL commit_seq[%0d]: got %h expected %h", i, obs, exp_obs());
            else passes++;
        end
        checks++;
        if ({load, blink, set_h1, set_h0, set_m1, set_m0} !== {1'b1, 1'b0, 16'h1437})
            $display("FAIL commit_load: got load=%b blink=%b set=%h expected load=1 blink=0 set=1437",
                     load, blink, {set_h1, set_h0, set_m1, set_m0});
        else passes++;
        tick(3'b000);
        checks++;
        if ({load, set_active, digit_sel} !== 4'b0000)
            $display("FAIL commit_after: got load=%b active=%b sel=%0d expected 0 0 0", load, set_active, digit_sel);
        else passes++;
    endtask

    task automatic test_inc_24h();
        logic [3:0] want[4] = '{4'd1, 4'd2, 4'd3, 4'd0};
        fmt12 = 1'b0;
        set_cur(4'd1, 4'd7, 4'd0, 4'd0);
        tick(3'b100); tick(3'b000); tick(3'b001);
        checks++;
        if ({set_h1, set_h0} !== 8'h20) $display("FAIL inc24_h1: got %h expected 20", {set_h1, set_h0});
        else passes++;
        tick(3'b000); tick(3'b010); tick(3'b000);
        for (int i = 0; i < 4; i++) begin
            tick(3'b001);
            checks++;
            if (set_h0 !== want[i] || obs !== exp_obs())
                $display("FAIL inc24_h0[%0d]: got h0=%0d obs=%h expected h0=%0d obs=%h", i, set_h0, obs, want[i], exp_obs());
            else passes++;
            tick(3'b000);
        end
        tick(3'b100); tick(3'b000);
    endtask

    task automatic test_inc_12h();
        fmt12 = 1'b1;
        set_cur(4'd0, 4'd9, 4'd5, 4'd9);
        tick(3'b100); tick(3'b000); tick(3'b001);
        checks++;
        if ({set_h1, set_h0} !== 8'h10) $display("FAIL inc12_h1_up: got %h expected 10", {set_h1, set_h0});
        else passes++;
        tick(3'b000); tick(3'b001);
        checks++;
        if ({set_h1, set_h0} !== 8'h01) $display("FAIL inc12_h1_wrap: got %h expected 01", {set_h1, set_h0});
        else passes++;
        tick(3'b000); tick(3'b010); tick(3'b000); tick(3'b010); tick(3'b000); tick(3'b001);
        checks++;
        if (set_m1 !== 4'd0 || digit_sel !== 2'd1) $display("FAIL inc12_m1_wrap: got m1=%0d sel=%0d expected 0 1", set_m1, digit_sel);
        else passes++;
        tick(3'b000); tick(3'b010); tick(3'b000); tick(3'b001);
        checks++;
        if ({set_m1, set_m0} !== 8'h00 || obs !== exp_obs())
            $display("FAIL inc12_m0_wrap: got %h obs=%h expected 00 obs=%h", {set_m1, set_m0}, obs, exp_obs());
        else passes++;
        tick(3'b100); tick(3'b000);
        fmt12 = 1'b0;
    endtask

    task automatic test_abort_same_cycle();
        set_cur(4'd2, 4'd2, 4'd4, 4'd4);
        tick(3'b100); tick(3'b000); tick(3'b010); tick(3'b000);
        tick(3'b101);
        checks++;
        if ({set_active, load, set_h0} !== {2'b00, 4'd2} || obs !== exp_obs())
            $display("FAIL abort_mode_up: got active=%b load=%b h0=%0d expected 0 0 2", set_active, load, set_h0);
        else passes++;
        tick(3'b000);
    endtask

    task automatic test_timeout();
        int  cnt;
        logic saw_load;
        tick(3'b100); tick(3'b000); tick(3'b010); tick(3'b000); tick(3'b010); tick(3'b000);
        tick(3'b010);
        cnt = 0;
        saw_load = 1'b0;
        for (int i = 0; i < 2 * TO && set_active; i++) begin
            cnt++;
            tick(3'b000);
            saw_load |= load;
        end
        checks++;
        if (cnt !== TO || saw_load !== 1'b0 || set_active !== 1'b0)
            $display("FAIL timeout: got %0d active cycles load=%b active=%b expected %0d 0 0", cnt, saw_load, set_active, TO);
        else passes++;
        checks++;
        if (obs !== exp_obs()) $display("FAIL timeout_model: got %h expected %h", obs, exp_obs());
        else passes++;
    endtask

    task automatic test_held_up();
        set_cur(4'd1, 4'd2, 4'd3, 4'd3);
        tick(3'b100); tick(3'b000); tick(3'b010); tick(3'b000); tick(3'b010); tick(3'b000); tick(3'b010); tick(3'b000);
        repeat (10) tick(3'b001);
        tick(3'b000);
        checks++;
        if (set_m0 !== 4'd4 || obs !== exp_obs())
            $display("FAIL held_up: got m0=%0d obs=%h expected m0=4 obs=%h", set_m0, obs, exp_obs());
        else passes++;
        tick(3'b100); tick(3'b000);
    endtask

    task automatic test_blink();
        int   toggles;
        logic last;
        tick(3'b100);
        last = blink;
        toggles = 0;
        for (int i = 0; i < 19; i++) begin
            tick(3'b000);
            if (blink !== last) toggles++;
            last = blink;
            checks++;
            if (obs !== exp_obs()) $display("FAIL blink_seq[%0d]: got %h expected %h", i, obs, exp_obs());
            else passes++;
        end
        checks++;
        if (toggles !== 4) $display("FAIL blink_toggles: got %0d expected 4", toggles);
        else passes++;
        for (int i = 0; i < 4; i++) begin
            tick(3'b010); tick(3'b000);
        end
        checks++;
        if (blink !== 1'b0 || set_active !== 1'b0) $display("FAIL blink_idle: got blink=%b active=%b expected 0 0", blink, set_active);
        else passes++;
    endtask

    task automatic test_reset_mid();
        logic saw_load;
        tick(3'b100); tick(3'b000); tick(3'b010); tick(3'b000); tick(3'b010); tick(3'b000);
        checks++;
        if (digit_sel !== 2'd1) $display("FAIL reset_mid_pre: got sel=%0d expected 1", digit_sel);
        else passes++;
        @(negedge clk);
        #2 reset = 1'b1;
        model_reset();
        #1;
        checks++;
        if (obs !== 21'd0) $display("FAIL reset_mid_async: got %h expected 0", obs);
        else passes++;
        saw_load = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            saw_load |= load;
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(3'b000);
            saw_load |= load;
        end
        checks++;
        if (saw_load !== 1'b0 || obs !== exp_obs())
            $display("FAIL reset_mid_release: got load=%b obs=%h expected load=0 obs=%h", saw_load, obs, exp_obs());
        else passes++;
    endtask

    task automatic test_random();
        int errs;
        logic [2:0] b;
        errs = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) == 0)
                set_cur(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                        4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 49) == 0) fmt12 = ~fmt12;
            b[2] = ($urandom_range(0, 24) == 0);
            b[1] = ($urandom_range(0, 5) == 0);
            b[0] = ($urandom_range(0, 2) == 0);
            tick(b);
            checks++;
            if (obs !== exp_obs()) begin
                if (errs < 10) $display("FAIL random[%0d]: got %h expected %h", i, obs, exp_obs());
                errs++;
            end else passes++;
        end
    endtask

    initial begin
        reset = 1'b1;
        btn_mode = 1'b0; btn_next = 1'b0; btn_up = 1'b0; fmt12 = 1'b0;
        set_cur(4'd0, 4'd0, 4'd0, 4'd0);
        test_reset();
        test_commit();
        test_inc_24h();
        test_inc_12h();
        test_abort_same_cycle();
        test_timeout();
        test_held_up();
        test_blink();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d done", passes, checks);
        $fatal(1);
    end

endmodule
